// File: rtl/ex_mem_stage_pkg.sv
// Shared EX/MEM definitions: FSM encoding, write-class codes and the implicit R15 ID.
// The forwarding unit and writeback stage import the same constants.
package ex_mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  localparam logic [1:0] RW_NONE   = 2'b00;
  localparam logic [1:0] RW_OP1    = 2'b01;
  localparam logic [1:0] RW_OP12   = 2'b10;
  localparam logic [1:0] RW_OP1R15 = 2'b11;

  localparam logic [3:0] REG_R15 = 4'd15;

  // A write class is only advertised for a real instruction that is no longer waiting on memory.
  function automatic logic [1:0] qualify_rwrite(input logic       valid,
                                                input logic       idle,
                                                input logic [1:0] rw);
    return (valid && idle) ? rw : RW_NONE;
  endfunction

endpackage

// File: rtl/ex_mem_wait_ctr.sv
// Wait-cycle counter for an outstanding data-memory access.
// o_expired flags the last permitted wait cycle (count == TIMEOUT-1).
module ex_mem_wait_ctr #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int              CTR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CTR_W-1:0] LAST = CTR_W'(TIMEOUT - 1);

  logic [CTR_W-1:0] r_count;

  // Saturates at LAST so a missed clear can never wrap back into a valid wait window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && !o_expired) begin
      r_count <= r_count + CTR_W'(1);
    end
  end

  assign o_expired = (r_count == LAST);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with data-memory request/ack handshake and timeout.
// Stalls upstream while an access is outstanding; forwarding info is gated until the access completes.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic [REG_W-1:0]  ex_op1,
  input  logic [REG_W-1:0]  ex_op2,
  input  logic [DATA_W-1:0] ex_op1data,
  input  logic [DATA_W-1:0] ex_op2data,
  input  logic [DATA_W-1:0] ex_r15data,
  input  logic [1:0]        ex_rwrite,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [REG_W-1:0]  memop1,
  output logic [REG_W-1:0]  memop2,
  output logic [DATA_W-1:0] memop1data,
  output logic [DATA_W-1:0] memop2data,
  output logic [DATA_W-1:0] memr15data,
  output logic [1:0]        rwrite,
  output logic              mem_valid,
  output logic              stall_up,
  output logic              mem_err
);

  state_e r_state;
  state_e w_next;

  logic [REG_W-1:0]  r_op1, r_op2;
  logic [DATA_W-1:0] r_op1data, r_op2data, r_r15data;
  logic [DATA_W-1:0] r_addr, r_wdata;
  logic [1:0]        r_rwrite;
  logic              r_valid, r_mem_read, r_we;

  logic w_capture, w_bubble, w_ack_take;
  logic w_ctr_clr, w_ctr_inc, w_expired;
  logic w_ex_store, w_ex_mem;

  // Read wins when both memory flags are set, so only a pure write counts as a store.
  assign w_ex_store = ex_mem_write && !ex_mem_read;
  assign w_ex_mem   = ex_mem_read || ex_mem_write;

  ex_mem_wait_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_ctr_clr),
    .i_inc     (w_ctr_inc),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // flush beats mem_ack in WAIT; ack beats timeout on the last wait cycle.
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    w_bubble   = 1'b0;
    w_ack_take = 1'b0;
    w_ctr_clr  = 1'b0;
    w_ctr_inc  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_ctr_clr = 1'b1;
        if (flush || !ex_valid) begin
          w_bubble = 1'b1;
        end else begin
          w_capture = 1'b1;
          if (w_ex_mem) begin
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flush) begin
          w_bubble  = 1'b1;
          w_ctr_clr = 1'b1;
          w_next    = ST_IDLE;
        end else if (mem_ack) begin
          w_ack_take = 1'b1;
          w_ctr_clr  = 1'b1;
          w_next     = ST_IDLE;
        end else if (w_expired) begin
          w_ctr_clr = 1'b1;
          w_next    = ST_ERR;
        end else begin
          w_ctr_inc = 1'b1;
        end
      end
      ST_ERR: begin
        w_ctr_clr = 1'b1;
        if (flush) begin
          w_bubble = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // A bubble clears every field so nothing stale can reach the forwarding unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_op1data  <= '0;
      r_op2data  <= '0;
      r_r15data  <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rwrite   <= RW_NONE;
      r_valid    <= 1'b0;
      r_mem_read <= 1'b0;
      r_we       <= 1'b0;
    end else if (w_bubble) begin
      r_op1      <= '0;
      r_op2      <= '0;
      r_op1data  <= '0;
      r_op2data  <= '0;
      r_r15data  <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rwrite   <= RW_NONE;
      r_valid    <= 1'b0;
      r_mem_read <= 1'b0;
      r_we       <= 1'b0;
    end else if (w_capture) begin
      r_op1      <= ex_op1;
      r_op2      <= ex_op2;
      r_op1data  <= ex_op1data;
      r_op2data  <= ex_op2data;
      r_r15data  <= ex_r15data;
      r_addr     <= ex_addr;
      r_wdata    <= ex_wdata;
      r_rwrite   <= w_ex_store ? RW_NONE : ex_rwrite;
      r_valid    <= 1'b1;
      r_mem_read <= ex_mem_read;
      r_we       <= w_ex_store;
    end else if (w_ack_take && r_mem_read) begin
      r_op1data  <= mem_rdata;
    end
  end

  // Request is decoded from state so an async reset drops it without waiting for a clock.
  assign mem_req   = (r_state == ST_WAIT);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign stall_up  = (r_state != ST_IDLE);
  assign mem_err   = (r_state == ST_ERR);

  assign memop1     = r_op1;
  assign memop2     = r_op2;
  assign memop1data = r_op1data;
  assign memop2data = r_op2data;
  assign memr15data = r_r15data;
  assign mem_valid  = r_valid;
  assign rwrite     = qualify_rwrite(r_valid, r_state == ST_IDLE, r_rwrite);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed scoreboard bench for ex_mem_stage: ALU, load, store, timeout, flush and async-reset cases.
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush, ex_valid, ex_mem_read, ex_mem_write, mem_ack;
  logic [REG_W-1:0]  ex_op1, ex_op2;
  logic [DATA_W-1:0] ex_op1data, ex_op2data, ex_r15data, ex_addr, ex_wdata, mem_rdata;
  logic [1:0]        ex_rwrite;
  logic              mem_req, mem_we, mem_valid, stall_up, mem_err;
  logic [DATA_W-1:0] mem_addr, mem_wdata, memop1data, memop2data, memr15data;
  logic [REG_W-1:0]  memop1, memop2;
  logic [1:0]        rwrite;

  typedef struct {
    logic [REG_W-1:0]  op1;
    logic [REG_W-1:0]  op2;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
    logic [DATA_W-1:0] d15;
    logic [1:0]        rw;
    logic              valid;
    logic              bubble;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   reqCycles, stallCycles, errEarly;

  always #5 clk = ~clk;

  ex_mem_stage #(
    .DATA_W  (DATA_W),
    .REG_W   (REG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_op1data   (ex_op1data),
    .ex_op2data   (ex_op2data),
    .ex_r15data   (ex_r15data),
    .ex_rwrite    (ex_rwrite),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_addr      (ex_addr),
    .ex_wdata     (ex_wdata),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .memop1       (memop1),
    .memop2       (memop2),
    .memop1data   (memop1data),
    .memop2data   (memop2data),
    .memr15data   (memr15data),
    .rwrite       (rwrite),
    .mem_valid    (mem_valid),
    .stall_up     (stall_up),
    .mem_err      (mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    flush        = 1'b0;
    ex_valid     = 1'b0;
    ex_op1       = '0;
    ex_op2       = '0;
    ex_op1data   = '0;
    ex_op2data   = '0;
    ex_r15data   = '0;
    ex_rwrite    = RW_NONE;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_addr      = '0;
    ex_wdata     = '0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
  endtask

  // Drives one EX instruction; when track is set, the expected stage contents after completion are queued.
  task automatic applyStimulus(input logic track, input logic [REG_W-1:0] op1, input logic [REG_W-1:0] op2,
                               input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2,
                               input logic [DATA_W-1:0] d15, input logic [1:0] rw,
                               input logic rd, input logic wr, input logic [DATA_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] loadData);
    exp_t e;
    ex_valid     = 1'b1;
    ex_op1       = op1;
    ex_op2       = op2;
    ex_op1data   = d1;
    ex_op2data   = d2;
    ex_r15data   = d15;
    ex_rwrite    = rw;
    ex_mem_read  = rd;
    ex_mem_write = wr;
    ex_addr      = addr;
    ex_wdata     = wdata;
    if (track) begin
      e.op1    = op1;
      e.op2    = op2;
      e.d1     = rd ? loadData : d1;
      e.d2     = d2;
      e.d15    = d15;
      e.rw     = (wr && !rd) ? RW_NONE : rw;
      e.valid  = 1'b1;
      e.bubble = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic pushBubble();
    exp_t e;
    e.op1    = '0;
    e.op2    = '0;
    e.d1     = '0;
    e.d2     = '0;
    e.d15    = '0;
    e.rw     = RW_NONE;
    e.valid  = 1'b0;
    e.bubble = 1'b1;
    sb.push_back(e);
  endtask

  task automatic checkScoreboard(input string tag);
    exp_t e;
    checkOutput({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput({tag, "_mem_valid"}, 32'(mem_valid), 32'(e.valid));
      checkOutput({tag, "_rwrite"}, 32'(rwrite), 32'(e.rw));
      if (!e.bubble) begin
        checkOutput({tag, "_memop1"}, 32'(memop1), 32'(e.op1));
        checkOutput({tag, "_memop2"}, 32'(memop2), 32'(e.op2));
        checkOutput({tag, "_memop1data"}, 32'(memop1data), 32'(e.d1));
        checkOutput({tag, "_memop2data"}, 32'(memop2data), 32'(e.d2));
        checkOutput({tag, "_memr15data"}, 32'(memr15data), 32'(e.d15));
      end
    end
  endtask

  initial begin
    idleInputs();
    rst_n = 1'b0;
    repeat (2) tick();
    checkOutput("rst_memop1", 32'(memop1), 32'd0);
    checkOutput("rst_memop1data", 32'(memop1data), 32'd0);
    checkOutput("rst_rwrite", 32'(rwrite), 32'(RW_NONE));
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_stall_up", 32'(stall_up), 32'd0);
    checkOutput("rst_mem_err", 32'(mem_err), 32'd0);
    checkOutput("rst_mem_valid", 32'(mem_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_memop1", 32'(memop1), 32'd0);
    checkOutput("idle_stall_up", 32'(stall_up), 32'd0);
    checkOutput("idle_mem_valid", 32'(mem_valid), 32'd0);

    $display("[TB] ALU op1 write");
    applyStimulus(1'b1, 4'd3, 4'd5, 16'h1234, 16'h5678, 16'h0000, RW_OP1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    checkScoreboard("alu1");
    checkOutput("alu1_stall_up", 32'(stall_up), 32'd0);

    $display("[TB] ALU op1+R15 with stray ack");
    idleInputs();
    applyStimulus(1'b1, 4'd10, 4'd11, 16'h0A0A, 16'h0B0B, 16'h0F0F, RW_OP1R15, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    checkScoreboard("alu2");

    $display("[TB] load, ack after 3 wait cycles");
    idleInputs();
    applyStimulus(1'b1, 4'd7, 4'd0, 16'h0000, 16'h0000, 16'h0000, RW_OP1, 1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF);
    tick();
    reqCycles   = 0;
    stallCycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req) reqCycles++;
      if (stall_up) stallCycles++;
      checkOutput("load_addr", 32'(mem_addr), 32'h0040);
      checkOutput("load_we", 32'(mem_we), 32'd0);
      checkOutput("load_wait_rwrite", 32'(rwrite), 32'(RW_NONE));
      if (i == 3) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hBEEF;
      end
      tick();
    end
    mem_ack = 1'b0;
    checkOutput("load_req_cycles", 32'(reqCycles), 32'd4);
    checkOutput("load_stall_cycles", 32'(stallCycles), 32'd4);
    checkOutput("load_done_req", 32'(mem_req), 32'd0);
    checkOutput("load_done_stall", 32'(stall_up), 32'd0);
    checkScoreboard("load");

    $display("[TB] store with immediate ack");
    idleInputs();
    applyStimulus(1'b1, 4'd9, 4'd0, 16'h1111, 16'h0000, 16'h0000, RW_OP1, 1'b0, 1'b1, 16'h0080, 16'hCAFE, 16'h0);
    tick();
    checkOutput("store_req", 32'(mem_req), 32'd1);
    checkOutput("store_we", 32'(mem_we), 32'd1);
    checkOutput("store_addr", 32'(mem_addr), 32'h0080);
    checkOutput("store_wdata", 32'(mem_wdata), 32'hCAFE);
    mem_ack   = 1'b1;
    mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    checkScoreboard("store");
    checkOutput("store_done_stall", 32'(stall_up), 32'd0);

    $display("[TB] load with no ack, timeout");
    idleInputs();
    applyStimulus(1'b0, 4'd4, 4'd0, 16'h0, 16'h0, 16'h0, RW_OP1, 1'b1, 1'b0, 16'h0100, 16'h0, 16'h0);
    tick();
    reqCycles = 0;
    errEarly  = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (mem_req) reqCycles++;
      if (mem_err) errEarly++;
      tick();
    end
    checkOutput("to_req_cycles", 32'(reqCycles), 32'(TIMEOUT));
    checkOutput("to_err_early", 32'(errEarly), 32'd0);
    checkOutput("to_mem_err", 32'(mem_err), 32'd1);
    checkOutput("to_mem_req", 32'(mem_req), 32'd0);
    checkOutput("to_stall_up", 32'(stall_up), 32'd1);
    repeat (3) tick();
    checkOutput("to_err_sticky", 32'(mem_err), 32'd1);
    checkOutput("to_stall_sticky", 32'(stall_up), 32'd1);
    idleInputs();
    flush = 1'b1;
    pushBubble();
    tick();
    flush = 1'b0;
    checkOutput("to_flush_err", 32'(mem_err), 32'd0);
    checkOutput("to_flush_stall", 32'(stall_up), 32'd0);
    checkOutput("to_flush_req", 32'(mem_req), 32'd0);
    checkScoreboard("to_flush");

    $display("[TB] flush and ack in the same wait cycle");
    applyStimulus(1'b0, 4'd6, 4'd0, 16'h0, 16'h0, 16'h0, RW_OP1, 1'b1, 1'b0, 16'h0200, 16'h0, 16'h0);
    tick();
    checkOutput("fa_req", 32'(mem_req), 32'd1);
    idleInputs();
    flush     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 16'hAAAA;
    pushBubble();
    tick();
    flush   = 1'b0;
    mem_ack = 1'b0;
    checkScoreboard("flush_ack");
    checkOutput("fa_req_after", 32'(mem_req), 32'd0);
    checkOutput("fa_stall_after", 32'(stall_up), 32'd0);

    $display("[TB] async reset mid-access");
    applyStimulus(1'b0, 4'd1, 4'd0, 16'h0, 16'h0, 16'h0, RW_OP1, 1'b1, 1'b0, 16'h0300, 16'h0, 16'h0);
    tick();
    checkOutput("ar_req_before", 32'(mem_req), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("ar_req_dropped", 32'(mem_req), 32'd0);
    checkOutput("ar_stall_dropped", 32'(stall_up), 32'd0);
    idleInputs();
    #1 rst_n = 1'b1;
    tick();

    $display("[TB] read+write treated as load");
    applyStimulus(1'b1, 4'd12, 4'd0, 16'h3333, 16'h0000, 16'h0000, RW_OP1, 1'b1, 1'b1, 16'h0400, 16'h7777, 16'h4242);
    tick();
    checkOutput("rw_we", 32'(mem_we), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'h4242;
    tick();
    mem_ack = 1'b0;
    checkScoreboard("rdwr");

    $display("[TB] ALU op1+op2 after recovery");
    idleInputs();
    applyStimulus(1'b1, 4'd2, 4'd8, 16'h2222, 16'h8888, 16'h0000, RW_OP12, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    checkScoreboard("alu3");
    idleInputs();

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
